qos_vc_dequeue: RTL and testbench
=================================

Name: qos_vc_dequeue

Overview:
- Downstream consumer of the 4-VC round-robin/weighted arbiter's one-hot grant.
- Each cycle, pops one word from the granted virtual-channel FIFO and places it in a single-entry output register with valid/ready handshake toward the PCIe transmit path.
- Flags illegal grants and empty-VC grants.
- Keeps per-VC transmitted-word counters for QoS monitoring.

Parameters:
- DATA_WIDTH, 8, width of one FIFO word / output word
- CNT_WIDTH, 16, width of each per-VC transmitted-word counter
- NUM_VC, 4, number of virtual channels; fixed at 4 to match the arbiter's 4-bit grant; other values unsupported

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- enb  in  1  block enable; 0 = no pops, output register still drains
- grant  in  4  one-hot VC grant from arbiter; bit i = VC i
- fifo_empty  in  4  per-VC empty flag from the show-ahead (FWFT) VC FIFOs
- fifo_data  in  4*DATA_WIDTH  per-VC head word; VC i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- fifo_pop  out  4  combinational pop strobe to VC FIFOs, at most one bit high
- out_data  out  DATA_WIDTH  registered output word
- out_vc  out  2  binary index of the VC that out_data came from
- out_valid  out  1  out_data/out_vc valid
- out_ready  in  1  downstream accepts when out_valid && out_ready at a rising edge
- grant_miss  out  1  registered 1-cycle pulse: the granted VC was empty while a load was possible
- grant_err  out  1  sticky flag: a multi-hot grant was seen while enb=1; cleared only by reset
- cnt_sel  in  2  selects the VC counter shown on cnt_out
- cnt_out  out  CNT_WIDTH  combinational read of counter[cnt_sel]

Behaviour:
- Reset (synchronous, active-high): on a clk edge with reset=1:
  - out_valid=0, out_data=0, out_vc=0, grant_miss=0, grant_err=0.
  - All four counters = 0; FSM = EMPTY.
  - fifo_pop is forced 0 while reset=1.
- FSM states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Definitions:
  - onehot = grant has exactly one bit set; g = its index.
  - space = (state==EMPTY) || out_ready.
  - load = enb && onehot && !fifo_empty[g] && space.
- fifo_pop[g] = load (combinational, same cycle); all other pop bits are 0. The FIFO consumes its head on that edge.
- On a load edge:
  - out_data <= fifo_data slice g; out_vc <= g; state -> FULL.
  - counter[g] <= counter[g]+1, wrapping modulo 2^CNT_WIDTH.
- FULL && out_ready && !load -> EMPTY, out_valid=0.
- FULL && out_ready && load -> stays FULL with the new word. Back-to-back throughput is 1 word/cycle.
- FULL && !out_ready -> hold; out_data/out_vc stay stable; no pop regardless of grant.
- Latency: a word popped at edge N is visible on out_data after edge N.
- grant=0 -> no pop, no flag.
- Multi-hot grant with enb=1 -> no pop; grant_err set on that edge and held.
- enb && onehot && fifo_empty[g] && space -> no pop; grant_miss=1 for exactly the next cycle. Otherwise grant_miss=0.
- enb=0 -> no pop, no flags. The output register still drains via out_ready.
- Reset during FULL: the held word is discarded (not retransmitted). A pop coinciding with reset never occurs.
- grant may change every cycle; it is sampled combinationally. No internal grant latching.

Decomposition:
- Shared package qos_pkg holds:
  - NUM_VC=4, VC_IDX_W=2.
  - Enum vc_deq_state_t {EMPTY, FULL}.
  - Functions is_onehot4() and onehot4_to_idx(), reused by the arbiter's bench and checker.
- One natural sub-module: qos_vc_counter_bank (4 x CNT_WIDTH wrapping counters, inc strobe + index, read mux).

Test Plan:
- Reset, then grant=4'b0001, fifo_empty=4'b0000, VC0 head=8'hA5, out_ready=1, enb=1 -> fifo_pop=4'b0001 same cycle; next cycle out_valid=1, out_data=8'hA5, out_vc=0; cnt_sel=0 gives cnt_out=1.
- Rotate grant 0001,0010,0100,1000 with heads 11/22/33/44, out_ready=1 -> outputs 11,22,33,44 on consecutive cycles, out_vc 0..3, each counter=1.
- Load VC2 word 8'h5A, hold out_ready=0 for 3 cycles with grant=4'b0100 -> out_data stays 5A, fifo_pop stays 0; raising out_ready pops the next word on that same edge.
- grant=4'b0010 with fifo_empty[1]=1 -> no pop, grant_miss pulses one cycle, out_valid falls after out_ready drains.
- grant=4'b0101, enb=1 -> no pop; grant_err=1 and stays 1 after legal grants resume until reset. The same grant with enb=0 leaves grant_err=0.
- Preload counter[3] to 2^CNT_WIDTH-1 via pops, then one more pop -> cnt_out wraps to 0. Assert reset while FULL -> out_valid=0 and all counters=0 after that edge.

Source files
------------

// File: rtl/qos_pkg.sv
// rtl/qos_pkg.sv - shared QoS virtual-channel types, constants and grant helpers
package qos_pkg;

    localparam int NUM_VC   = 4;
    localparam int VC_IDX_W = 2;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } vc_deq_state_t;

    function automatic logic is_onehot4(input logic [NUM_VC-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Non-one-hot inputs map to 0; callers gate on is_onehot4 first.
    function automatic logic [VC_IDX_W-1:0] onehot4_to_idx(input logic [NUM_VC-1:0] v);
        logic [VC_IDX_W-1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/qos_vc_counter_bank.sv
// rtl/qos_vc_counter_bank.sv - per-VC wrapping transmitted-word counters with read mux
module qos_vc_counter_bank
    import qos_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic [VC_IDX_W-1:0] inc_idx,
    input  logic [VC_IDX_W-1:0] rd_idx,
    output logic [CNT_WIDTH-1:0] rd_data
);

    logic [CNT_WIDTH-1:0] cnt [NUM_VC];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VC; i++) begin
                cnt[i] <= '0;
            end
        end else if (inc) begin
            cnt[inc_idx] <= cnt[inc_idx] + 1'b1;
        end
    end

    assign rd_data = cnt[rd_idx];

endmodule

// File: rtl/qos_vc_dequeue.sv
// rtl/qos_vc_dequeue.sv - pops the granted VC FIFO into a single-entry output register
module qos_vc_dequeue
    import qos_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enb,
    input  logic [NUM_VC-1:0]            grant,
    input  logic [NUM_VC-1:0]            fifo_empty,
    input  logic [NUM_VC*DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_VC-1:0]            fifo_pop,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [VC_IDX_W-1:0]          out_vc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         grant_miss,
    output logic                         grant_err,
    input  logic [VC_IDX_W-1:0]          cnt_sel,
    output logic [CNT_WIDTH-1:0]         cnt_out
);

    localparam logic [0:0] ST_EMPTY = EMPTY;
    localparam logic [0:0] ST_FULL  = FULL;

    logic [0:0]            state;
    logic                  onehot;
    logic [VC_IDX_W-1:0]   g;
    logic [DATA_WIDTH-1:0] head_word;
    logic                  space;
    logic                  attempt;
    logic                  load;
    logic                  miss;
    logic                  multi;

    always_comb begin
        onehot    = is_onehot4(grant);
        g         = onehot4_to_idx(grant);
        head_word = fifo_data[g*DATA_WIDTH +: DATA_WIDTH];
        space     = (state == ST_EMPTY) || out_ready;
        // Pops are suppressed during reset so the FIFOs never lose a word to a discarded load.
        attempt   = !reset && enb && onehot && space;
        load      = attempt && !fifo_empty[g];
        miss      = attempt && fifo_empty[g];
        multi     = enb && (grant != '0) && !onehot;
        fifo_pop  = load ? grant : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            out_data   <= '0;
            out_vc     <= '0;
            grant_miss <= 1'b0;
            grant_err  <= 1'b0;
        end else begin
            grant_miss <= miss;
            if (multi) begin
                grant_err <= 1'b1;
            end
            if (load) begin
                state    <= ST_FULL;
                out_data <= head_word;
                out_vc   <= g;
            end else if ((state == ST_FULL) && out_ready) begin
                state <= ST_EMPTY;
            end
        end
    end

    assign out_valid = (state == ST_FULL);

    qos_vc_counter_bank #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (load),
        .inc_idx (g),
        .rd_idx  (cnt_sel),
        .rd_data (cnt_out)
    );

endmodule

// File: tb/tb_qos_vc_dequeue.sv
// tb/tb_qos_vc_dequeue.sv - self-checking bench for qos_vc_dequeue
module tb_qos_vc_dequeue;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enb;
    logic [3:0]    grant;
    logic [3:0]    fifo_empty;
    logic [4*DW-1:0] fifo_data;
    logic [3:0]    fifo_pop;
    logic [DW-1:0] out_data;
    logic [1:0]    out_vc;
    logic          out_valid;
    logic          out_ready;
    logic          grant_miss;
    logic          grant_err;
    logic [1:0]    cnt_sel;
    logic [CW-1:0] cnt_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    qos_vc_dequeue #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .grant      (grant),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .out_data   (out_data),
        .out_vc     (out_vc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant_miss (grant_miss),
        .grant_err  (grant_err),
        .cnt_sel    (cnt_sel),
        .cnt_out    (cnt_out)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: transaction-level view of the output slot and counters.
    bit      m_valid;
    int      m_data;
    int      m_vc;
    bit      m_miss;
    bit      m_err;
    int      m_cnt [4];

    function automatic int first_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit model_load();
        int i;
        i = first_idx(grant);
        return !reset && enb && ($countones(grant) == 1) && !fifo_empty[i]
               && (!m_valid || out_ready);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 0; m_data = 0; m_vc = 0; m_miss = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            int idx;
            bit ld;
            idx = first_idx(grant);
            ld = model_load();
            m_miss = enb && ($countones(grant) == 1) && fifo_empty[idx] && (!m_valid || out_ready);
            if (enb && $countones(grant) > 1) m_err = 1;
            if (ld) begin
                m_valid = 1;
                m_data = int'(fifo_data[idx*DW +: DW]);
                m_vc = idx;
                m_cnt[idx] = (m_cnt[idx] + 1) % (1 << CW);
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic [3:0] exp_pop;
            exp_pop = model_load() ? (4'b0001 << first_idx(grant)) : 4'b0000;
            chk("m_pop", fifo_pop, exp_pop);
            chk("m_valid", out_valid, m_valid);
            chk("m_data", out_data, m_data);
            chk("m_vc", out_vc, m_vc);
            chk("m_miss", grant_miss, m_miss);
            chk("m_err", grant_err, m_err);
            chk("m_cnt", cnt_out, m_cnt[cnt_sel]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        grant = 4'b0000;
        cyc();
        reset = 1'b0;
    endtask

    logic [DW-1:0] rot_exp [4];

    initial begin
        reset = 1'b1; enb = 1'b0; grant = '0; fifo_empty = '1; fifo_data = '0;
        out_ready = 1'b0; cnt_sel = '0;
        cyc();
        check_en = 1'b1;
        cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_err", grant_err, 0);
        chk("rst_cnt", cnt_out, 0);

        // single pop from VC0
        reset = 1'b0; enb = 1'b1; out_ready = 1'b1; fifo_empty = 4'b0000;
        fifo_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        grant = 4'b0001;
        #1 chk("t1_pop", fifo_pop, 4'b0001);
        cyc();
        grant = 4'b0000;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 8'hA5);
        chk("t1_vc", out_vc, 0);
        chk("t1_cnt", cnt_out, 1);

        // rotating grants, back-to-back
        do_reset();
        fifo_data = {8'h44, 8'h33, 8'h22, 8'h11};
        rot_exp[0] = 8'h11; rot_exp[1] = 8'h22; rot_exp[2] = 8'h33; rot_exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            grant = 4'b0001 << i;
            cyc();
            chk("t2_data", out_data, rot_exp[i]);
            chk("t2_vc", out_vc, i);
        end
        grant = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1 chk("t2_cnt", cnt_out, 1);
        end
        cnt_sel = 2'd0;

        // backpressure hold on VC2
        cyc();
        fifo_data[2*DW +: DW] = 8'h5A;
        grant = 4'b0100;
        cyc();
        out_ready = 1'b0;
        fifo_data[2*DW +: DW] = 8'h5B;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_pop_hold", fifo_pop, 4'b0000);
            cyc();
            chk("t3_hold_data", out_data, 8'h5A);
        end
        out_ready = 1'b1;
        #1 chk("t3_pop_release", fifo_pop, 4'b0100);
        cyc();
        chk("t3_next_data", out_data, 8'h5B);

        // grant to an empty VC
        grant = 4'b0010; fifo_empty = 4'b0010;
        #1 chk("t4_pop", fifo_pop, 4'b0000);
        cyc();
        grant = 4'b0000;
        chk("t4_miss", grant_miss, 1);
        chk("t4_valid", out_valid, 0);
        cyc();
        chk("t4_miss_clr", grant_miss, 0);
        fifo_empty = 4'b0000;

        // multi-hot grant, disabled then enabled
        enb = 1'b0; grant = 4'b0101;
        cyc();
        chk("t5_err_dis", grant_err, 0);
        enb = 1'b1;
        #1 chk("t5_pop", fifo_pop, 4'b0000);
        cyc();
        chk("t5_err_set", grant_err, 1);
        grant = 4'b0001;
        cyc(); cyc();
        chk("t5_err_held", grant_err, 1);
        do_reset();
        chk("t5_err_rst", grant_err, 0);

        // counter wrap on VC3, then reset while FULL
        cnt_sel = 2'd3;
        grant = 4'b1000;
        repeat ((1 << CW) - 1) cyc();
        chk("t6_cnt_max", cnt_out, (1 << CW) - 1);
        cyc();
        chk("t6_cnt_wrap", cnt_out, 0);
        chk("t6_full", out_valid, 1);
        reset = 1'b1;
        cyc();
        chk("t6_rst_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1 chk("t6_rst_cnt", cnt_out, 0);
        end
        reset = 1'b0; grant = 4'b0000;
        cyc();
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
